// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: widths, requester indices
// and the access state encoding.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int WORD_W = 16;
    localparam int NREQ   = 3;

    localparam int REQ_LD = 0;
    localparam int REQ_IF = 1;
    localparam int REQ_DT = 2;

    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO,
        DONE
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational priority picker for the memory port arbiter.
// The loader always wins. With ARB_ROUND_ROBIN_EN defined, fetch and data
// alternate using the last-granted pointer; otherwise data beats fetch.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic            last_dt_i,
    output logic [NREQ-1:0] win_o
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_dt;
    assign unused_last_dt = last_dt_i;
`endif

    // Select exactly one requester, loader first, then fetch/data policy.
    always_comb begin
        win_o = '0;
        if (req_i[REQ_LD]) begin
            win_o[REQ_LD] = 1'b1;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (req_i[REQ_IF] && req_i[REQ_DT]) begin
            if (last_dt_i) begin
                win_o[REQ_IF] = 1'b1;
            end else begin
                win_o[REQ_DT] = 1'b1;
            end
        end
`endif
        else if (req_i[REQ_DT]) begin
            win_o[REQ_DT] = 1'b1;
        end else if (req_i[REQ_IF]) begin
            win_o[REQ_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide memory port between the loader,
// instruction fetch and data access. Word accesses become two byte beats,
// high byte at the even address. Odd-address word accesses are rejected.
// Optional feature macro: ARB_ROUND_ROBIN_EN (fetch/data alternate).
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16,
    parameter int NREQ   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ-1:0]        bsel,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*WORD_W-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [WORD_W-1:0]      rdata,
    output logic                   odd_err,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata
);

    import mem_port_arbiter_pkg::*;

    arb_state_t          state_q, state_d;
    logic [NREQ-1:0]     sel_q, sel_d;
    logic                we_q, we_d;
    logic                bsel_q, bsel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [7:0]          hi_q, hi_d;

    logic [NREQ-1:0]     win;
    logic                last_dt;
    logic                win_we;
    logic                win_bsel;
    logic [ADDR_W-1:0]   win_addr;
    logic [WORD_W-1:0]   win_wdata;

    mem_arb_pick u_pick (
        .req_i     (req),
        .last_dt_i (last_dt),
        .win_o     (win)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dt_q, last_dt_d;

    // Move the fetch/data pointer only on fetch or data grants.
    always_comb begin
        last_dt_d = last_dt_q;
        if (state_q == IDLE && !reset && (win[REQ_IF] || win[REQ_DT])) begin
            last_dt_d = win[REQ_DT];
        end
    end

    // Pointer register; after reset data counts as last granted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_dt_q <= 1'b1;
        end else begin
            last_dt_q <= last_dt_d;
        end
    end

    assign last_dt = last_dt_q;
`else
    assign last_dt = 1'b1;
`endif

    // Route the winning requester's fields to the capture registers.
    always_comb begin
        win_we    = 1'b0;
        win_bsel  = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (win[n]) begin
                win_we    = we[n];
                win_bsel  = bsel[n];
                win_addr  = addr[n*ADDR_W +: ADDR_W];
                win_wdata = wdata[n*WORD_W +: WORD_W];
            end
        end
    end

    // Access sequencer: next state, field capture and port outputs.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        we_d      = we_q;
        bsel_d    = bsel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        hi_d      = hi_q;
        gnt       = '0;
        done      = '0;
        rdata     = '0;
        odd_err   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                gnt = reset ? '0 : win;
                if (|win) begin
                    sel_d   = win;
                    we_d    = win_we;
                    bsel_d  = win_bsel;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    err_d   = !win_bsel && win_addr[0];
                    state_d = (!win_bsel && win_addr[0]) ? DONE : HI;
                end
            end
            HI: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = bsel_q ? wdata_q[7:0] : wdata_q[15:8];
                state_d   = bsel_q ? DONE : LO;
            end
            LO: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[ADDR_W-1:1], 1'b1};
                mem_wdata = wdata_q[7:0];
                hi_d      = mem_rdata;
                state_d   = DONE;
            end
            DONE: begin
                done    = sel_q;
                odd_err = err_q;
                if (err_q || we_q) begin
                    rdata = '0;
                end else if (bsel_q) begin
                    rdata = {{(WORD_W-8){1'b0}}, mem_rdata};
                end else begin
                    rdata = {hi_q, mem_rdata};
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-field registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            bsel_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            bsel_q  <= bsel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            hi_q    <= hi_d;
        end
    end

endmodule
